// File: rtl/snoop_bus_controller_pkg.sv
// Shared definitions for the snooping bus controller: sizes, request kinds,
// controller FSM encoding and the MESI codes used by the attached caches.
package snoop_bus_pkg;
  localparam int N_PROC_DEF = 3;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] KIND_RD_MISS = 2'd0;
  localparam logic [1:0] KIND_WR_MISS = 2'd1;
  localparam logic [1:0] KIND_INV     = 2'd2;
  localparam logic [1:0] KIND_RSVD    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BCAST   = 3'd1,
    ST_SNOOP   = 3'd2,
    ST_WB      = 3'd3,
    ST_MEM     = 3'd4,
    ST_MEMWAIT = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_M = 2'd2,
    MESI_E = 2'd3
  } mesi_e;

  // The reserved kind behaves like an invalidate (no data movement).
  function automatic logic is_inv_kind(input logic [1:0] kind);
    return (kind == KIND_INV) || (kind == KIND_RSVD);
  endfunction
endpackage

// File: rtl/snoop_bus_controller_if.sv
// Bus bundle between the controller (master) and the processors, snoopers
// and main memory (slave).
interface snoop_bus_if
  import snoop_bus_pkg::*;
#(
  parameter int N_PROC = N_PROC_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic [N_PROC-1:0]        req;
  logic [2*N_PROC-1:0]      req_kind;
  logic [ADDR_W*N_PROC-1:0] req_addr;
  logic [N_PROC-1:0]        gnt;
  logic                     bus_valid;
  logic [1:0]               bus_kind;
  logic [ADDR_W-1:0]        bus_addr;
  logic [N_PROC-1:0]        snoop_shared;
  logic [N_PROC-1:0]        snoop_dirty;
  logic [DATA_W*N_PROC-1:0] snoop_wb_data;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_we;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic [N_PROC-1:0]        done;
  logic [DATA_W-1:0]        rd_data;
  logic                     shared_out;

  modport master (
    input  req, req_kind, req_addr, snoop_shared, snoop_dirty, snoop_wb_data, mem_rdata,
    output gnt, bus_valid, bus_kind, bus_addr, mem_addr, mem_we, mem_wdata, done,
           rd_data, shared_out
  );

  modport slave (
    output req, req_kind, req_addr, snoop_shared, snoop_dirty, snoop_wb_data, mem_rdata,
    input  gnt, bus_valid, bus_kind, bus_addr, mem_addr, mem_we, mem_wdata, done,
           rd_data, shared_out
  );
endinterface

// File: rtl/snoop_bus_controller_rr_arbiter.sv
// Combinational round-robin pick: searches upward from the slot after ptr,
// wrapping modulo N; the caller owns the pointer register.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  // First requester at ptr+1, ptr+2, ... wins.
  always_comb begin
    int j;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end
endmodule

// File: rtl/snoop_bus_controller.sv
// Shared-bus controller: round-robin grant, snoop broadcast, dirty write-back
// and memory fill for the MESI caches. All bus outputs are registered.
module snoop_bus_controller
  import snoop_bus_pkg::*;
#(
  parameter int N_PROC = N_PROC_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  snoop_bus_if.master     bus,
  output logic            protocol_err
);
  localparam int IDX_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam logic [N_PROC-1:0] ONE_HOT0 = {{(N_PROC-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, ptr_q, ptr_d, arb_idx_s, dirty_idx_s;
  logic [1:0]          kind_q, kind_d, bus_kind_q, bus_kind_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, bus_addr_q, bus_addr_d, mem_addr_q, mem_addr_d;
  logic [N_PROC-1:0]   gnt_q, gnt_d, done_q, done_d, arb_gnt_s;
  logic [N_PROC-1:0]   masked_shared_s, masked_dirty_s;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d, rd_data_q, rd_data_d, wb_data_s;
  logic                bus_valid_q, bus_valid_d, mem_we_q, mem_we_d;
  logic                shared_q, shared_d, perr_q, perr_d, arb_valid_s, multi_dirty_s;

  rr_arbiter #(.N(N_PROC), .IDX_W(IDX_W)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  // Snoop responses from everyone but the requester; lowest dirty index wins.
  always_comb begin
    masked_shared_s = bus.snoop_shared & ~gnt_q;
    masked_dirty_s  = bus.snoop_dirty & ~gnt_q;
    multi_dirty_s   = (masked_dirty_s & (masked_dirty_s - ONE_HOT0)) != '0;
    dirty_idx_s     = '0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (masked_dirty_s[i]) dirty_idx_s = IDX_W'(i);
      else                   dirty_idx_s = dirty_idx_s;
    end
    wb_data_s = bus.snoop_wb_data[DATA_W*dirty_idx_s +: DATA_W];
  end

  // Next state, latched request fields and registered output values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    kind_d    = kind_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    shared_d  = shared_q;
    perr_d    = perr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          idx_d   = arb_idx_s;
          kind_d  = bus.req_kind[2*arb_idx_s +: 2];
          addr_d  = bus.req_addr[ADDR_W*arb_idx_s +: ADDR_W];
          state_d = ST_BCAST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BCAST: state_d = ST_SNOOP;
      ST_SNOOP: begin
        if (kind_q == KIND_WR_MISS) shared_d = 1'b0;
        else                        shared_d = |masked_shared_s;
        if (multi_dirty_s || (kind_q == KIND_RSVD)) perr_d = 1'b1;
        else                                        perr_d = perr_q;
        if (is_inv_kind(kind_q)) begin
          rd_data_d = '0;
          state_d   = ST_DONE;
        end else if (|masked_dirty_s) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB:  state_d = ST_MEM;
      ST_MEM: state_d = ST_MEMWAIT;
      ST_MEMWAIT: begin
        rd_data_d = bus.mem_rdata;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        ptr_d   = idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they line up with it.
    bus_valid_d = (state_d == ST_BCAST);
    bus_kind_d  = (state_d == ST_BCAST) ? kind_d : 2'd0;
    bus_addr_d  = (state_d == ST_BCAST) ? addr_d : '0;
    mem_we_d    = (state_d == ST_WB);
    mem_wdata_d = (state_d == ST_WB) ? wb_data_s : '0;
    mem_addr_d  = ((state_d == ST_WB) || (state_d == ST_MEM)) ? addr_d : '0;
    done_d      = (state_d == ST_DONE) ? (ONE_HOT0 << idx_d) : '0;
    if (state_d == ST_IDLE)      gnt_d = '0;
    else if (state_q == ST_IDLE) gnt_d = arb_gnt_s;
    else                         gnt_d = gnt_q;
  end

  // State and output registers; reset forces everything idle immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ptr_q       <= IDX_W'(N_PROC - 1);
      kind_q      <= 2'd0;
      addr_q      <= '0;
      gnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_kind_q  <= 2'd0;
      bus_addr_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      done_q      <= '0;
      rd_data_q   <= '0;
      shared_q    <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      gnt_q       <= gnt_d;
      bus_valid_q <= bus_valid_d;
      bus_kind_q  <= bus_kind_d;
      bus_addr_q  <= bus_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
      shared_q    <= shared_d;
      perr_q      <= perr_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.bus_valid  = bus_valid_q;
  assign bus.bus_kind   = bus_kind_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.done       = done_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.shared_out = shared_q;
  assign protocol_err   = perr_q;
endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed bench for snoop_bus_controller with a registered 32x8 memory model.
module tb_snoop_bus_controller;
  import snoop_bus_pkg::*;
  localparam int NP = 3;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset;
  logic protocol_err;
  always #5 clock = ~clock;

  snoop_bus_if #(.N_PROC(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  snoop_bus_controller #(.N_PROC(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .protocol_err (protocol_err)
  );

  // Main memory: registered read, write from the DUT or from the bench preload.
  logic [DW-1:0] mem [32];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_data;
  always @(posedge clock) begin
    if (bus.mem_we)  mem[bus.mem_addr] <= bus.mem_wdata;
    else if (tb_we)  mem[tb_addr] <= tb_data;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic mem_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    @(posedge clock);
    #1 tb_we = 1'b0;
  endtask

  // Per-transaction observations, cycle 0 = first IDLE cycle seeing req.
  int            valid_cyc, done_cyc, we_cnt;
  logic [NP-1:0] done_v, gnt_v;
  logic [1:0]    bkind;
  logic [AW-1:0] baddr, wb_addr;
  logic [DW-1:0] wb_data, rd_v;
  logic          sh_v;

  task automatic run(input int budget);
    valid_cyc = -1; done_cyc = -1; we_cnt = 0;
    done_v = '0; gnt_v = '0; bkind = '0; baddr = '0;
    wb_addr = '0; wb_data = '0; rd_v = '0; sh_v = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (bus.bus_valid) begin
        valid_cyc = c; bkind = bus.bus_kind; baddr = bus.bus_addr; gnt_v = bus.gnt;
      end
      if (bus.mem_we) begin
        we_cnt++; wb_addr = bus.mem_addr; wb_data = bus.mem_wdata;
      end
      if (bus.done != '0) begin
        done_cyc = c; done_v = bus.done; rd_v = bus.rd_data; sh_v = bus.shared_out;
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  logic [NP-1:0] rr_exp [4];
  logic [DW-1:0] rr_rd  [4];
  logic          done_seen;

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_rd  = '{8'h11, 8'h22, 8'h33, 8'h11};
    reset = 1'b1;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    bus.req = '0; bus.req_kind = '0; bus.req_addr = '0;
    bus.snoop_shared = '0; bus.snoop_dirty = '0; bus.snoop_wb_data = '0;
    mem_load(5'h0A, 8'h3C);
    mem_load(5'h11, 8'h55);
    mem_load(5'h01, 8'h11);
    mem_load(5'h02, 8'h22);
    mem_load(5'h03, 8'h33);
    mem_load(5'h15, 8'hE1);
    mem_load(5'h08, 8'h6D);
    @(negedge clock);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_valid_we", 32'({bus.bus_valid, bus.mem_we}), 32'd0);
    check("rst_perr", 32'(protocol_err), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Proc1 clean read miss.
    bus.req = 3'b010; bus.req_kind = 6'b00_00_00; bus.req_addr = {5'd0, 5'h0A, 5'd0};
    run(12);
    bus.req = '0;
    check("t1_valid_cyc", 32'(valid_cyc), 32'd1);
    check("t1_gnt", 32'(gnt_v), 32'b010);
    check("t1_done_cyc", 32'(done_cyc), 32'd5);
    check("t1_done", 32'(done_v), 32'b010);
    check("t1_rd", 32'(rd_v), 32'h3C);
    check("t1_shared", 32'(sh_v), 32'd0);
    check("t1_no_we", 32'(we_cnt), 32'd0);

    // Proc0 read miss, proc2 holds the line Modified.
    bus.snoop_shared = 3'b100; bus.snoop_dirty = 3'b100; bus.snoop_wb_data = {8'hA5, 8'h00, 8'h00};
    bus.req = 3'b001; bus.req_addr = {5'd0, 5'd0, 5'h11};
    run(12);
    bus.req = '0; bus.snoop_shared = '0; bus.snoop_dirty = '0;
    check("t2_we_cnt", 32'(we_cnt), 32'd1);
    check("t2_wb_addr", 32'(wb_addr), 32'h11);
    check("t2_wb_data", 32'(wb_data), 32'hA5);
    check("t2_done_cyc", 32'(done_cyc), 32'd6);
    check("t2_done", 32'(done_v), 32'b001);
    check("t2_rd", 32'(rd_v), 32'hA5);
    check("t2_shared", 32'(sh_v), 32'd1);
    check("t2_mem", 32'(mem[5'h11]), 32'hA5);
    check("t2_perr", 32'(protocol_err), 32'd0);

    // Proc2 invalidate, proc0 holds a shared copy.
    bus.snoop_shared = 3'b001;
    bus.req = 3'b100; bus.req_kind = {KIND_INV, 2'd0, 2'd0}; bus.req_addr = {5'h04, 5'd0, 5'd0};
    run(12);
    bus.req = '0; bus.snoop_shared = '0; bus.req_kind = '0;
    check("t3_bus_kind", 32'(bkind), 32'd2);
    check("t3_bus_addr", 32'(baddr), 32'h04);
    check("t3_done_cyc", 32'(done_cyc), 32'd3);
    check("t3_done", 32'(done_v), 32'b100);
    check("t3_no_we", 32'(we_cnt), 32'd0);
    check("t3_rd", 32'(rd_v), 32'd0);
    check("t3_shared", 32'(sh_v), 32'd1);

    // All three request continuously: fair rotation 0,1,2,0.
    bus.req = 3'b111; bus.req_addr = {5'd3, 5'd2, 5'd1};
    for (int t = 0; t < 4; t++) begin
      run(12);
      check($sformatf("t4_done_%0d", t), 32'(done_v), 32'(rr_exp[t]));
      check($sformatf("t4_cyc_%0d", t), 32'(done_cyc), 32'd5);
      check($sformatf("t4_rd_%0d", t), 32'(rd_v), 32'(rr_rd[t]));
    end
    bus.req = '0;

    // Two dirty snoopers: error flagged, lowest index supplies data.
    bus.snoop_dirty = 3'b110; bus.snoop_wb_data = {8'h99, 8'h77, 8'h00};
    bus.req = 3'b001; bus.req_addr = {5'd0, 5'd0, 5'h15};
    run(12);
    bus.req = '0; bus.snoop_dirty = '0;
    check("t5_wb_data", 32'(wb_data), 32'h77);
    check("t5_rd", 32'(rd_v), 32'h77);
    check("t5_done_cyc", 32'(done_cyc), 32'd6);
    check("t5_perr", 32'(protocol_err), 32'd1);
    bus.req = 3'b010; bus.req_addr = {5'd0, 5'h0A, 5'd0};
    run(12);
    bus.req = '0;
    check("t5_perr_sticky", 32'(protocol_err), 32'd1);
    check("t5_clean_rd", 32'(rd_v), 32'h3C);

    // Reset in the write-back cycle.
    bus.snoop_dirty = 3'b001; bus.snoop_wb_data = {8'h00, 8'h00, 8'h42};
    bus.req = 3'b010; bus.req_addr = {5'd0, 5'h08, 5'd0};
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("t6_in_wb", 32'({bus.mem_we, bus.mem_wdata}), 32'h142);
    reset = 1'b1;
    #1;
    check("t6_we_async", 32'(bus.mem_we), 32'd0);
    check("t6_gnt_async", 32'(bus.gnt), 32'd0);
    check("t6_perr_clr", 32'(protocol_err), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; bus.req = '0; bus.snoop_dirty = '0;
    done_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (bus.done != '0) done_seen = 1'b1;
    end
    check("t6_no_done", 32'(done_seen), 32'd0);
    check("t6_mem_kept", 32'(mem[5'h08]), 32'h6D);
    @(posedge clock); #1;
    bus.req = 3'b111; bus.req_addr = {5'd3, 5'd2, 5'd1};
    run(12);
    bus.req = '0;
    check("t6_first_gnt", 32'(done_v), 32'b001);
    check("t6_first_rd", 32'(rd_v), 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snoop_bus_controller.md
Name: snoop_bus_controller

Overview:
- Shared-bus controller between the per-processor MESI caches and the 32x8 main memory.
- Arbitrates bus requests from N_PROC processors round-robin and broadcasts the winning transaction to the snooping caches.
- Collects snoop responses, performs the write-back/abort sequence when a snooper holds the block Modified, then fetches the line from memory.
- Returns fill data plus a shared indication so the requester installs the line as Exclusive or Shared.

Parameters:
- N_PROC, 3, number of processors on the bus.
- ADDR_W, 5, memory address width (32 words).
- DATA_W, 8, data word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_PROC  per-processor bus request; held high until that processor's done pulse.
- req_kind  in  2*N_PROC  per-processor kind: 0 read miss, 1 write miss, 2 invalidate (S->M upgrade), 3 reserved.
- req_addr  in  ADDR_W*N_PROC  per-processor block address.
- gnt  out  N_PROC  one-hot grant; high from BCAST through DONE.
- bus_valid  out  1  one-cycle broadcast strobe to the snoopers.
- bus_kind  out  2  latched kind of the granted request.
- bus_addr  out  ADDR_W  latched address of the granted request.
- snoop_shared  in  N_PROC  snooper holds the block valid (S/E/M); sampled in SNOOP.
- snoop_dirty  in  N_PROC  snooper holds the block Modified, i.e. abort + write-back; sampled in SNOOP.
- snoop_wb_data  in  DATA_W*N_PROC  dirty data from each snooper.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; registered, valid one cycle after address.
- done  out  N_PROC  one-hot, one-cycle completion pulse to the requester.
- rd_data  out  DATA_W  fill data; valid with done.
- shared_out  out  1  another cache kept a copy; valid with done.
- protocol_err  out  1  sticky; set when more than one snooper reports dirty.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; round-robin pointer = N_PROC-1, so proc 0 has priority first; protocol_err cleared. Memory contents are not reset.
- FSM states: IDLE, BCAST, SNOOP, WB, MEM, MEMWAIT, DONE.
- IDLE:
  - If any req is high, pick the first requester at index pointer+1, pointer+2, ... (mod N_PROC).
  - Latch its index, kind and addr, then go to BCAST. Otherwise stay.
- BCAST: gnt is one-hot; bus_valid=1 for exactly this cycle; bus_kind and bus_addr are driven from the latched values. Go to SNOOP.
- SNOOP:
  - Sample snoop_shared and snoop_dirty, masking the granted index.
  - shared_out latch = OR of the masked shared bits; for kind 1, shared_out is forced to 0.
  - kind 2: go to DONE; rd_data = 0.
  - Any masked dirty bit: go to WB.
  - Otherwise: go to MEM.
  - More than one masked dirty bit: set protocol_err and use the lowest dirty index.
- WB: mem_we=1, mem_addr=latched addr, mem_wdata=snoop_wb_data of the selected dirty snooper; go to MEM.
- MEM: mem_we=0, mem_addr=latched addr; go to MEMWAIT.
- MEMWAIT: capture mem_rdata into rd_data; go to DONE.
- DONE:
  - done[granted]=1 for one cycle; rd_data and shared_out are held valid.
  - Pointer := granted index; gnt drops on the exit edge; go to IDLE.
- Latency, counting the cycle IDLE sees req as cycle 0:
  - Clean read or write miss: done in cycle 5.
  - Dirty snoop: done in cycle 6.
  - Invalidate: done in cycle 3.
- Requester handshake: deassert req on the edge where done is sampled high. A req still high in the following IDLE cycle is treated as a new request.
- Request changes: changes in req_kind/req_addr after grant are ignored because the values are latched.
- A req dropping before done is not supported; the transaction still completes.
- Reserved kind 3: treated as kind 2 and sets protocol_err.
- Mid-transaction reset: immediate return to IDLE, no done pulse, mem_we forced to 0 asynchronously.
- Only one transaction is in flight at a time; there is no pipelining across grants.

Decomposition:
- Package snoop_bus_pkg: ADDR_W and DATA_W defaults; kind encodings KIND_RD_MISS=0, KIND_WR_MISS=1, KIND_INV=2; FSM state encoding; MESI state codes (I=0, S=1, M=2, E=3) shared with the cache/MESI logic.
- One sub-module, rr_arbiter: combinational round-robin pick. Inputs: req vector and pointer. Outputs: one-hot grant and index. The controller owns the pointer register.

Test Plan:
- Reset then proc1 read miss on addr 5'h0A, memory[0x0A]=8'h3C, no snoop bits -> bus_valid pulse in cycle 1; done=3'b010 in cycle 5; rd_data=8'h3C; shared_out=0; mem_we never high.
- Proc0 read miss on addr 0x11 with proc2 snoop_dirty=1 and snoop_wb_data=8'hA5 -> WB cycle with mem_we=1, mem_addr=0x11, mem_wdata=8'hA5; done=3'b001 in cycle 6; rd_data=8'hA5.
- Proc2 invalidate on addr 0x04 with proc0 snoop_shared=1 -> bus_kind=2 broadcast; done=3'b100 in cycle 3; no memory access.
- All three req high at once, each re-requesting immediately after done -> grant order 0,1,2,0; no processor granted twice while another waits.
- Proc0 read miss with proc1 and proc2 both dirty -> protocol_err=1 and stays 1; write-back data taken from proc1.
- Reset asserted during WB -> outputs 0 that same cycle, no done pulse, next request granted starting from proc 0.
